// File: rtl/pmod_pwm_rx.sv
// pmod_pwm_rx: receive side of the PMOD PWM link.
// Syncs the line, counts high time per 2^frame_log2 frame, emits signed samples.
module pmod_pwm_rx #(
  parameter int width       = 12,
  parameter int frame_log2  = 8,
  parameter int sync_stages = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    pwm_in,
  output logic signed [width-1:0] sample,
  output logic                    sample_valid,
  output logic                    stuck,
  output logic                    locked
);

  localparam int FW = frame_log2;
  localparam int CW = frame_log2 + 1;
  localparam int SH = width - frame_log2;

  localparam logic [FW-1:0] LAST = '1;
  localparam logic [FW-1:0] FLIP =
    FW'(1) << (FW - 1);
  localparam logic [width-1:0] MAXV =
    {1'b0, {(width-1){1'b1}}};

  typedef enum logic [1:0] {
    IDLE,
    ALIGN,
    RUN
  } state_t;

  state_t state_q, state_d;

  logic [sync_stages-1:0] sync_q;
  logic                   s_d_q;
  logic                   s;
  logic                   rise;
  logic                   toggle;

  logic [FW-1:0] align_q, align_d;
  logic [FW-1:0] frame_q, frame_d;
  logic [CW-1:0] ones_q, ones_d;
  logic [CW-1:0] cnt_c;
  logic          seen_q, seen_d;
  logic          seen_c;

  logic [width-1:0] sample_q, sample_d;
  logic [width-1:0] scaled;
  logic             valid_q, valid_d;
  logic             stuck_q, stuck_d;

  assign s      = sync_q[sync_stages-1];
  assign rise   = s & ~s_d_q;
  assign toggle = s ^ s_d_q;

  assign cnt_c  = ones_q + CW'(s);
  assign seen_c = seen_q | toggle;

  // Low FW bits of (c - N/2) are c with its top bit flipped;
  // c = N is the single value that overflows and saturates.
  assign scaled = cnt_c[FW] ? MAXV :
    {cnt_c[FW-1:0] ^ FLIP, {SH{1'b0}}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      s_d_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[sync_stages-2:0], pwm_in};
      s_d_q  <= s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      align_q  <= '0;
      frame_q  <= '0;
      ones_q   <= '0;
      seen_q   <= 1'b0;
      sample_q <= '0;
      valid_q  <= 1'b0;
      stuck_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      align_q  <= align_d;
      frame_q  <= frame_d;
      ones_q   <= ones_d;
      seen_q   <= seen_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
      stuck_q  <= stuck_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    align_d  = align_q;
    frame_d  = frame_q;
    ones_d   = ones_q;
    seen_d   = seen_q;
    sample_d = sample_q;
    valid_d  = 1'b0;
    stuck_d  = stuck_q;

    unique case (state_q)
      IDLE: begin
        align_d = '0;
        frame_d = '0;
        ones_d  = '0;
        seen_d  = 1'b0;
        if (en) state_d = ALIGN;
      end
      ALIGN: begin
        if (rise) begin
          // The rise cycle is frame cycle 0.
          state_d = RUN;
          align_d = '0;
          frame_d = FW'(1);
          ones_d  = CW'(1);
          seen_d  = 1'b1;
        end else if (align_q == LAST) begin
          state_d = RUN;
          align_d = '0;
          frame_d = '0;
          ones_d  = '0;
          seen_d  = 1'b0;
        end else begin
          align_d = align_q + FW'(1);
        end
      end
      RUN: begin
        if (frame_q == LAST) begin
          sample_d = scaled;
          valid_d  = 1'b1;
          stuck_d  = ~seen_c;
          frame_d  = '0;
          ones_d   = '0;
          seen_d   = 1'b0;
        end else begin
          frame_d = frame_q + FW'(1);
          ones_d  = cnt_c;
          seen_d  = seen_c;
        end
      end
      default: state_d = IDLE;
    endcase

    if (!en) begin
      state_d  = IDLE;
      align_d  = '0;
      frame_d  = '0;
      ones_d   = '0;
      seen_d   = 1'b0;
      sample_d = sample_q;
      valid_d  = 1'b0;
      stuck_d  = stuck_q;
    end
  end

  assign sample       = sample_q;
  assign sample_valid = valid_q;
  assign stuck        = stuck_q;
  assign locked       = (state_q == RUN);

endmodule

// File: tb/tb_pmod_pwm_rx.sv
// tb_pmod_pwm_rx: directed bench for pmod_pwm_rx.
// Frame-level model checked every cycle plus literal sample checks.
module tb_pmod_pwm_rx;

  localparam int W  = 12;
  localparam int FL = 8;
  localparam int SS = 2;
  localparam int N  = 1 << FL;

  localparam int M_IDLE  = 0;
  localparam int M_ALIGN = 1;
  localparam int M_RUN   = 2;

  logic clk;
  logic rst_n;
  logic en;
  logic pwm_in;
  logic signed [W-1:0] sample;
  logic sample_valid;
  logic stuck;
  logic locked;

  int errs   = 0;
  int checks = 0;
  int cyc    = 0;

  pmod_pwm_rx #(
    .width(W),
    .frame_log2(FL),
    .sync_stages(SS)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .pwm_in(pwm_in),
    .sample(sample),
    .sample_valid(sample_valid),
    .stuck(stuck),
    .locked(locked)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input int act,
                       input int exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  // Line generator: toggle every cycle, or PWM with period N.
  bit tog_mode = 1'b1;
  int hi_next  = 128;
  int hi_cur   = 128;
  int ph       = 0;

  initial begin
    pwm_in = 1'b0;
    forever begin
      @(negedge clk);
      if (tog_mode) begin
        pwm_in = ~pwm_in;
      end else begin
        if (ph == 0) hi_cur = hi_next;
        pwm_in = (ph < hi_cur);
        ph = (ph + 1) % N;
      end
    end
  end

  // Behavioural model: delayed line, frame collected as a queue.
  int m_pipe[SS];
  int m_prev   = 0;
  int m_mode   = M_IDLE;
  int m_acnt   = 0;
  int m_before = 0;
  int m_s      = 0;
  int m_q[$];
  int exp_sample = 0;
  int exp_valid  = 0;
  int exp_stuck  = 0;

  task automatic close_frame();
    int ones;
    int tg;
    int v;
    int pv;
    ones = 0;
    tg   = 0;
    for (int i = 0; i < N; i++) begin
      if (i == 0) pv = m_before;
      else pv = m_q[i-1];
      ones += m_q[i];
      if (m_q[i] != pv) tg = 1;
    end
    v = (ones - N / 2) * (1 << (W - FL));
    if (v > (1 << (W - 1)) - 1) v = (1 << (W - 1)) - 1;
    exp_sample = v;
    exp_stuck  = (tg == 0) ? 1 : 0;
    exp_valid  = 1;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SS; i++) m_pipe[i] = 0;
      m_prev     = 0;
      m_mode     = M_IDLE;
      m_acnt     = 0;
      m_before   = 0;
      m_q.delete();
      exp_sample = 0;
      exp_valid  = 0;
      exp_stuck  = 0;
    end else begin
      m_s = m_pipe[SS-1];
      exp_valid = 0;
      if (!en) begin
        m_mode = M_IDLE;
        m_q.delete();
      end else begin
        case (m_mode)
          M_IDLE: begin
            m_mode = M_ALIGN;
            m_acnt = 0;
          end
          M_ALIGN: begin
            if (m_s == 1 && m_prev == 0) begin
              m_mode = M_RUN;
              m_q.delete();
              m_before = m_prev;
              m_q.push_back(m_s);
            end else begin
              m_acnt++;
              if (m_acnt == N) begin
                m_mode = M_RUN;
                m_q.delete();
                m_before = m_s;
              end
            end
          end
          default: begin
            m_q.push_back(m_s);
            if (m_q.size() == N) begin
              close_frame();
              m_before = m_s;
              m_q.delete();
            end
          end
        endcase
      end
      for (int i = SS - 1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
      m_pipe[0] = int'(pwm_in);
      m_prev = m_s;
    end
  end

  always @(negedge clk) begin
    check("m_sample", int'(sample), exp_sample);
    check("m_valid", int'(sample_valid), exp_valid);
    check("m_stuck", int'(stuck), exp_stuck);
    check("m_locked", int'(locked), (m_mode == M_RUN) ? 1 : 0);
  end

  task automatic wait_valid(input int limit, output int t);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!sample_valid && k < limit);
    if (!sample_valid) check("valid_timeout", 0, 1);
    t = cyc;
  endtask

  initial begin
    int t0;
    int t1;
    int t2;
    int k;
    rst_n = 1'b0;
    en    = 1'b1;

    // Reset with a toggling line
    repeat (5) @(negedge clk);
    check("rst_sample", int'(sample), 0);
    check("rst_valid", int'(sample_valid), 0);
    check("rst_stuck", int'(stuck), 0);
    check("rst_locked", int'(locked), 0);
    rst_n = 1'b1;
    k = 0;
    while (!locked && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("lock_after_rise", int'(locked), 1);

    // 50% duty
    en = 1'b0;
    tog_mode = 1'b0;
    hi_next = 128;
    repeat (600) @(negedge clk);
    en = 1'b1;
    wait_valid(600, t0);
    check("d50_sample", int'(sample), 0);
    check("d50_stuck", int'(stuck), 0);
    wait_valid(300, t1);
    check("d50_sample2", int'(sample), 0);
    check("d50_period", t1 - t0, N);

    // 75% and 25% duty
    hi_next = 192;
    wait_valid(300, t0);
    wait_valid(300, t1);
    wait_valid(300, t2);
    check("d75_sample", int'(sample), 1024);
    check("d75_period", t2 - t1, N);
    hi_next = 64;
    wait_valid(300, t0);
    wait_valid(300, t1);
    wait_valid(300, t2);
    check("d25_sample", int'(sample), -1024);
    check("d25_stuck", int'(stuck), 0);
    check("d25_period", t2 - t1, N);

    // Constant high: align timeout, saturation
    en = 1'b0;
    hi_next = N;
    repeat (600) @(negedge clk);
    en = 1'b1;
    wait_valid(700, t0);
    check("hi_sample", int'(sample), 2047);
    check("hi_stuck", int'(stuck), 1);

    // Constant low
    hi_next = 0;
    wait_valid(300, t0);
    wait_valid(300, t1);
    wait_valid(300, t2);
    check("lo_sample", int'(sample), -2048);
    check("lo_stuck", int'(stuck), 1);
    check("lo_locked", int'(locked), 1);

    // Drop en at frame cycle 100
    wait_valid(300, t0);
    repeat (100) @(negedge clk);
    en = 1'b0;
    hi_next = 192;
    k = 0;
    repeat (400) begin
      @(negedge clk);
      if (sample_valid) k++;
    end
    check("en_lo_pulses", k, 0);
    check("en_lo_sample", int'(sample), -2048);
    check("en_lo_stuck", int'(stuck), 1);
    check("en_lo_locked", int'(locked), 0);
    en = 1'b1;
    wait_valid(600, t0);
    check("realign_sample", int'(sample), 1024);
    check("realign_stuck", int'(stuck), 0);

    // Asynchronous reset mid-frame
    wait_valid(300, t0);
    repeat (50) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_sample", int'(sample), 0);
    check("arst_valid", int'(sample_valid), 0);
    check("arst_stuck", int'(stuck), 0);
    check("arst_locked", int'(locked), 0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    k = 0;
    repeat (5) begin
      @(negedge clk);
      if (sample_valid) k++;
    end
    check("post_rst_pulses", k, 0);
    wait_valid(700, t0);
    check("post_rst_sample", int'(sample), 1024);

    repeat (10) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
